data_mem: RTL and testbench

Word-organised data memory for the single-cycle datapath, sitting directly downstream of the ALU. Address comes from the ALU result, store data from the second register-file read port. Supports word, halfword and byte stores with lane merging, and word/halfword/byte loads with sign or zero extension. Writes commit on the clock edge and emit a write log line for the course-style trace checker; reads are combinational.

---
 rtl/data_mem_if.sv | 11 +
 rtl/data_mem.sv | 42 ++++
 tb/tb_data_mem.sv | 118 +++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// data_mem_if: load/store bus between the ALU/register file and the data memory
interface data_mem_if;
  logic        WE;
  logic [2:0]  MemOp;
  logic [31:0] Addr;
  logic [31:0] WD;
  logic [31:0] PC;
  logic [31:0] RD;
  modport master(output WE, MemOp, Addr, WD, PC, input RD);
  modport slave(input WE, MemOp, Addr, WD, PC, output RD);
endinterface

// File: rtl/data_mem.sv
// data_mem: word-organised data memory with lane-merged stores and extending loads
module data_mem #(
  parameter int DEPTH = 3072
) (
  input logic clk,
  input logic reset,
  data_mem_if.slave bus
);
  logic [31:0] mem_q [DEPTH];
  logic [31:0] word, word_d;
  logic [15:0] half;
  logic [7:0]  lane;
  logic [11:0] idx;
  logic        in_range, rsvd, wr_en;
  assign idx      = bus.Addr[13:2];
  assign in_range = bus.Addr < 32'(4 * DEPTH);
  assign rsvd     = bus.MemOp > 3'd4;
  assign word     = in_range ? mem_q[idx] : '0;
  assign half     = word[{bus.Addr[1], 4'b0} +: 16];
  assign lane     = word[{bus.Addr[1:0], 3'b0} +: 8];
  assign wr_en    = bus.WE && !reset && in_range && !rsvd;
  // merge store data into the current word so partial stores keep the other lanes
  always_comb begin
    word_d = word;
    if (bus.MemOp == 3'd0) word_d = bus.WD;
    else if (bus.MemOp <= 3'd2) word_d[{bus.Addr[1], 4'b0} +: 16] = bus.WD[15:0];
    else word_d[{bus.Addr[1:0], 3'b0} +: 8] = bus.WD[7:0];
  end
  assign bus.RD = (!in_range || rsvd) ? '0 :
                  bus.MemOp == 3'd0   ? word :
                  bus.MemOp == 3'd1   ? {{16{half[15]}}, half} :
                  bus.MemOp == 3'd2   ? {16'h0, half} :
                  bus.MemOp == 3'd3   ? {{24{lane[7]}}, lane} :
                                        {24'h0, lane};
  always_ff @(posedge clk)
    if (reset) for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    else if (wr_en) mem_q[idx] <= word_d;
`ifndef SYNTHESIS
  always_ff @(posedge clk)
    if (wr_en) $display("@%h: *%h <= %h", bus.PC, {bus.Addr[31:2], 2'b00}, word_d);
`endif
endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: scoreboard bench for data_mem with directed cases and a byte-level reference model
module tb_data_mem;
  logic clk = 1'b0;
  logic reset;
  int total = 0, bad = 0, n_log = 0, exp_log = 0;
  logic [31:0] exp_q[$];
  logic [7:0] ref_m [12288];
  data_mem_if bus();
  data_mem dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (dut.wr_en === 1'b1) n_log++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic rst_v, input logic we, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc,
                      input bit chk, input logic [31:0] exp);
    @(posedge clk); #1;
    reset = rst_v; bus.WE = we; bus.MemOp = op; bus.Addr = a; bus.WD = wd; bus.PC = pc;
    if (chk) exp_q.push_back(exp);
    @(negedge clk);
    if (chk) check(tag, bus.RD, exp_q.pop_front());
  endtask

  task automatic ld(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] exp);
    step(tag, 1'b0, 1'b0, op, a, 32'h0, 32'h0, 1'b1, exp);
  endtask

  task automatic st(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc);
    step("st", 1'b0, 1'b1, op, a, wd, pc, 1'b0, 32'h0);
  endtask

  function automatic logic [31:0] mload(input logic [2:0] op, input logic [31:0] a);
    int b, h, y;
    if (a >= 32'h3000 || op > 3'd4) return 32'h0;
    y = int'(a);
    b = y & ~3;
    h = y & ~1;
    case (op)
      3'd0:    return {ref_m[b+3], ref_m[b+2], ref_m[b+1], ref_m[b]};
      3'd1:    return {{16{ref_m[h+1][7]}}, ref_m[h+1], ref_m[h]};
      3'd2:    return {16'h0, ref_m[h+1], ref_m[h]};
      3'd3:    return {{24{ref_m[y][7]}}, ref_m[y]};
      default: return {24'h0, ref_m[y]};
    endcase
  endfunction

  function automatic void mstore(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    int y;
    y = int'(a);
    if (op == 3'd0) for (int k = 0; k < 4; k++) ref_m[(y & ~3) + k] = wd[8*k +: 8];
    else if (op <= 3'd2) for (int k = 0; k < 2; k++) ref_m[(y & ~1) + k] = wd[8*k +: 8];
    else ref_m[y] = wd[7:0];
  endfunction

  initial begin
    logic        we;
    logic [2:0]  op;
    logic [31:0] a, wd;
    reset = 1'b1; bus.WE = 1'b0; bus.MemOp = 3'd0; bus.Addr = '0; bus.WD = '0; bus.PC = '0;
    step("rst", 1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    ld("rst_lo", 3'd0, 32'h0000, 32'h0);
    ld("rst_hi", 3'd0, 32'h2FFC, 32'h0);
    check("rst_log", 32'(n_log), 32'd0);
    step("sw_old", 1'b0, 1'b1, 3'd0, 32'h10, 32'h89ABCDEF, 32'h3000, 1'b1, 32'h0);
    ld("lw", 3'd0, 32'h13, 32'h89ABCDEF);
    st(3'd3, 32'h11, 32'h12345677, 32'h3004);
    ld("sb_word", 3'd0, 32'h10, 32'h89AB77EF);
    ld("lb", 3'd3, 32'h13, 32'hFFFFFF89);
    ld("lbu", 3'd4, 32'h13, 32'h00000089);
    st(3'd1, 32'h12, 32'h0000F00D, 32'h3008);
    ld("sh_word", 3'd0, 32'h10, 32'hF00D77EF);
    ld("lh", 3'd1, 32'h12, 32'hFFFFF00D);
    ld("lhu", 3'd2, 32'h10, 32'h000077EF);
    st(3'd0, 32'h3000, 32'hDEADBEEF, 32'h300C);
    ld("oor", 3'd0, 32'h3000, 32'h0);
    ld("top_untouched", 3'd0, 32'h2FFC, 32'h0);
    st(3'd0, 32'h2FFC, 32'hCAFEF00D, 32'h3010);
    ld("top", 3'd0, 32'h2FFC, 32'hCAFEF00D);
    ld("alias", 3'd0, 32'h4010, 32'h0);
    ld("oor_after", 3'd0, 32'h3000, 32'h0);
    st(3'd5, 32'h10, 32'h0, 32'h3014);
    ld("rsv_store", 3'd0, 32'h10, 32'hF00D77EF);
    ld("rsv_load5", 3'd5, 32'h10, 32'h0);
    ld("rsv_load7", 3'd7, 32'h10, 32'h0);
    step("sw20_old", 1'b0, 1'b1, 3'd0, 32'h20, 32'h11111111, 32'h3018, 1'b1, 32'h0);
    ld("sw20", 3'd0, 32'h20, 32'h11111111);
    check("log_count", 32'(n_log), 32'd5);
    step("rst_st", 1'b1, 1'b1, 3'd0, 32'h4, 32'hFFFFFFFF, 32'h301C, 1'b0, 32'h0);
    ld("rst_st", 3'd0, 32'h4, 32'h0);
    ld("rst_w10", 3'd0, 32'h10, 32'h0);
    ld("rst_lb", 3'd3, 32'h13, 32'h0);
    check("rst_log5", 32'(n_log), 32'd5);
    for (int i = 0; i < 12288; i++) ref_m[i] = 8'h0;
    exp_log = 5;
    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? 32'h2FF0 + 32'($urandom_range(0, 31)) : 32'($urandom_range(0, 63));
      wd = $urandom;
      step("rnd", 1'b0, we, op, a, wd, 32'h4000 + 32'(4 * i), 1'b1, mload(op, a));
      if (we && a < 32'h3000 && op <= 3'd4) begin
        mstore(op, a, wd);
        exp_log++;
      end
    end
    ld("rnd_last", 3'd0, 32'h0, mload(3'd0, 32'h0));
    check("rnd_log", 32'(n_log), 32'(exp_log));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
